// File: rtl/jtag_dtm_tap_if.sv
// DMI request/response bus between the JTAG DTM and the Debug Module.
// master = DTM side, slave = DM side.
interface jtag_dtm_tap_if #(
  parameter int unsigned ABITS = 7
);
  logic             DMI_REQ_VALID;
  logic             DMI_REQ_READY;
  logic [ABITS-1:0] DMI_REQ_ADDR;
  logic [31:0]      DMI_REQ_DATA;
  logic [1:0]       DMI_REQ_OP;
  logic             DMI_RESP_VALID;
  logic             DMI_RESP_READY;
  logic [31:0]      DMI_RESP_DATA;
  logic [1:0]       DMI_RESP_OP;

  modport master (
    output DMI_REQ_VALID, DMI_REQ_ADDR, DMI_REQ_DATA, DMI_REQ_OP, DMI_RESP_READY,
    input  DMI_REQ_READY, DMI_RESP_VALID, DMI_RESP_DATA, DMI_RESP_OP
  );

  modport slave (
    input  DMI_REQ_VALID, DMI_REQ_ADDR, DMI_REQ_DATA, DMI_REQ_OP, DMI_RESP_READY,
    output DMI_REQ_READY, DMI_RESP_VALID, DMI_RESP_DATA, DMI_RESP_OP
  );
endinterface

// File: rtl/jtag_dtm_tap.sv
// RISC-V 0.13 JTAG Debug Transport Module: 1149.1 TAP, IR, IDCODE, DTMCS, DMI, BYPASS.
// Issues DMI requests over a valid/ready handshake entirely in the TCK domain.
module jtag_dtm_tap #(
  parameter logic [31:0] IDCODE      = 32'h1000_0CFD,
  parameter int unsigned ABITS       = 7,
  parameter logic [2:0]  IDLE_CYCLES = 3'd1
) (
  input  logic           TCK,
  input  logic           TRSTB,
  input  logic           TMS,
  input  logic           TDI,
  output logic           TDO,
  jtag_dtm_tap_if.master dmi
);

  localparam int unsigned DRW = ABITS + 34;

  localparam logic [3:0] S_TLR      = 4'h0;
  localparam logic [3:0] S_RTI      = 4'h1;
  localparam logic [3:0] S_SEL_DR   = 4'h2;
  localparam logic [3:0] S_CAP_DR   = 4'h3;
  localparam logic [3:0] S_SH_DR    = 4'h4;
  localparam logic [3:0] S_EX1_DR   = 4'h5;
  localparam logic [3:0] S_PAUSE_DR = 4'h6;
  localparam logic [3:0] S_EX2_DR   = 4'h7;
  localparam logic [3:0] S_UPD_DR   = 4'h8;
  localparam logic [3:0] S_SEL_IR   = 4'h9;
  localparam logic [3:0] S_CAP_IR   = 4'hA;
  localparam logic [3:0] S_SH_IR    = 4'hB;
  localparam logic [3:0] S_EX1_IR   = 4'hC;
  localparam logic [3:0] S_PAUSE_IR = 4'hD;
  localparam logic [3:0] S_EX2_IR   = 4'hE;
  localparam logic [3:0] S_UPD_IR   = 4'hF;

  localparam logic [4:0] IR_IDCODE = 5'h01;
  localparam logic [4:0] IR_DTMCS  = 5'h10;
  localparam logic [4:0] IR_DMI    = 5'h11;

  logic [3:0]       state_q, state_d;
  logic [4:0]       ir_q, ir_d;
  logic [4:0]       ir_sr_q, ir_sr_d;
  logic [DRW-1:0]   dr_sr_q, dr_sr_d;
  logic [ABITS-1:0] addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic [1:0]       sticky_q, sticky_d;
  logic             pending_q, pending_d;
  logic             req_valid_q, req_valid_d;
  logic [ABITS-1:0] req_addr_q, req_addr_d;
  logic [31:0]      req_data_q, req_data_d;
  logic [1:0]       req_op_q, req_op_d;
  logic             resp_ready_q, resp_ready_d;
  logic             tdo_q, tdo_d;
  logic [1:0]       dmi_status;
  logic [1:0]       upd_op;
  logic [31:0]      dtmcs_cap;

  assign dtmcs_cap = {14'b0, 2'b0, 1'b0, IDLE_CYCLES, sticky_q, 6'(ABITS), 4'd1};
  assign upd_op    = dr_sr_q[1:0];

  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    ir_sr_d      = ir_sr_q;
    dr_sr_d      = dr_sr_q;
    addr_d       = addr_q;
    data_d       = data_q;
    sticky_d     = sticky_q;
    pending_d    = pending_q;
    req_valid_d  = req_valid_q;
    req_addr_d   = req_addr_q;
    req_data_d   = req_data_q;
    req_op_d     = req_op_q;
    resp_ready_d = resp_ready_q;
    dmi_status   = 2'd0;
    tdo_d        = 1'b0;

    unique case (state_q)
      S_TLR:      state_d = TMS ? S_TLR    : S_RTI;
      S_RTI:      state_d = TMS ? S_SEL_DR : S_RTI;
      S_SEL_DR:   state_d = TMS ? S_SEL_IR : S_CAP_DR;
      S_CAP_DR:   state_d = TMS ? S_EX1_DR : S_SH_DR;
      S_SH_DR:    state_d = TMS ? S_EX1_DR : S_SH_DR;
      S_EX1_DR:   state_d = TMS ? S_UPD_DR : S_PAUSE_DR;
      S_PAUSE_DR: state_d = TMS ? S_EX2_DR : S_PAUSE_DR;
      S_EX2_DR:   state_d = TMS ? S_UPD_DR : S_SH_DR;
      S_UPD_DR:   state_d = TMS ? S_SEL_DR : S_RTI;
      S_SEL_IR:   state_d = TMS ? S_TLR    : S_CAP_IR;
      S_CAP_IR:   state_d = TMS ? S_EX1_IR : S_SH_IR;
      S_SH_IR:    state_d = TMS ? S_EX1_IR : S_SH_IR;
      S_EX1_IR:   state_d = TMS ? S_UPD_IR : S_PAUSE_IR;
      S_PAUSE_IR: state_d = TMS ? S_EX2_IR : S_PAUSE_IR;
      S_EX2_IR:   state_d = TMS ? S_UPD_IR : S_SH_IR;
      S_UPD_IR:   state_d = TMS ? S_SEL_DR : S_RTI;
      default:    state_d = S_TLR;
    endcase

    unique case (state_q)
      S_TLR:    ir_d    = IR_IDCODE;
      S_CAP_IR: ir_sr_d = 5'b00001;
      S_SH_IR:  ir_sr_d = {TDI, ir_sr_q[4:1]};
      S_UPD_IR: ir_d    = ir_sr_q;
      default:  ;
    endcase

    // Bus handshakes resolve before capture so a coincident capture sees the response.
    if (req_valid_q && dmi.DMI_REQ_READY) begin
      req_valid_d  = 1'b0;
      resp_ready_d = 1'b1;
    end
    if (resp_ready_q && dmi.DMI_RESP_VALID) begin
      data_d       = dmi.DMI_RESP_DATA;
      pending_d    = 1'b0;
      resp_ready_d = 1'b0;
      if (dmi.DMI_RESP_OP != 2'd0 && sticky_q == 2'd0) sticky_d = 2'd2;
    end

    unique case (state_q)
      S_CAP_DR: begin
        unique case (ir_q)
          IR_IDCODE: dr_sr_d = DRW'(IDCODE);
          IR_DTMCS:  dr_sr_d = DRW'(dtmcs_cap);
          IR_DMI: begin
            if (sticky_d != 2'd0) dmi_status = sticky_d;
            else if (pending_d)   dmi_status = 2'd3;
            dr_sr_d = {addr_q, data_d, dmi_status};
            if (pending_d) sticky_d = 2'd3;
          end
          default:   dr_sr_d = '0;
        endcase
      end
      S_SH_DR: begin
        dr_sr_d = dr_sr_q >> 1;
        unique case (ir_q)
          IR_IDCODE, IR_DTMCS: dr_sr_d[31]    = TDI;
          IR_DMI:              dr_sr_d[DRW-1] = TDI;
          default:             dr_sr_d[0]     = TDI;
        endcase
      end
      S_UPD_DR: begin
        if (ir_q == IR_DTMCS) begin
          if (dr_sr_q[17]) begin
            sticky_d     = 2'd0;
            pending_d    = 1'b0;
            req_valid_d  = 1'b0;
            resp_ready_d = 1'b0;
          end else if (dr_sr_q[16]) begin
            sticky_d = 2'd0;
          end
        end else if (ir_q == IR_DMI && (upd_op == 2'd1 || upd_op == 2'd2)) begin
          if (pending_d) begin
            sticky_d = 2'd3;
          end else if (sticky_d == 2'd0) begin
            addr_d      = dr_sr_q[DRW-1 -: ABITS];
            data_d      = dr_sr_q[33:2];
            pending_d   = 1'b1;
            req_valid_d = 1'b1;
            req_addr_d  = dr_sr_q[DRW-1 -: ABITS];
            req_data_d  = dr_sr_q[33:2];
            req_op_d    = upd_op;
          end
        end
      end
      default: ;
    endcase

    if (state_q == S_SH_IR)      tdo_d = ir_sr_q[0];
    else if (state_q == S_SH_DR) tdo_d = dr_sr_q[0];
  end

  always_ff @(posedge TCK or posedge TRSTB) begin
    if (TRSTB) begin
      state_q      <= S_TLR;
      ir_q         <= IR_IDCODE;
      ir_sr_q      <= '0;
      dr_sr_q      <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      sticky_q     <= 2'd0;
      pending_q    <= 1'b0;
      req_valid_q  <= 1'b0;
      req_addr_q   <= '0;
      req_data_q   <= '0;
      req_op_q     <= 2'd0;
      resp_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ir_q         <= ir_d;
      ir_sr_q      <= ir_sr_d;
      dr_sr_q      <= dr_sr_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      sticky_q     <= sticky_d;
      pending_q    <= pending_d;
      req_valid_q  <= req_valid_d;
      req_addr_q   <= req_addr_d;
      req_data_q   <= req_data_d;
      req_op_q     <= req_op_d;
      resp_ready_q <= resp_ready_d;
    end
  end

  // TDO launches on the falling edge so the probe samples it on the next rising edge.
  always_ff @(negedge TCK or posedge TRSTB) begin
    if (TRSTB) tdo_q <= 1'b0;
    else       tdo_q <= tdo_d;
  end

  assign TDO                = tdo_q;
  assign dmi.DMI_REQ_VALID  = req_valid_q;
  assign dmi.DMI_REQ_ADDR   = req_addr_q;
  assign dmi.DMI_REQ_DATA   = req_data_q;
  assign dmi.DMI_REQ_OP     = req_op_q;
  assign dmi.DMI_RESP_READY = resp_ready_q;

endmodule

// File: doc/jtag_dtm_tap.md
Name: jtag_dtm_tap

Overview:
- RISC-V JTAG Debug Transport Module (spec 0.13) on target 0 of the JTAG debug bridge.
- Consumes the bridge's TGT_TCK/TGT_TMS/TGT_TDI/TGT_TRSTB outputs and returns TDO to TGT_TDO.
- Implements the IEEE 1149.1 TAP FSM, IR, IDCODE, DTMCS, DMI and BYPASS.
- Issues DMI read/write requests to the Debug Module over a valid/ready handshake in the TCK domain. CDC to the core clock lives downstream.

Parameters:
- IDCODE, 32'h1000_0CFD, IDCODE register value; bit 0 must be 1.
- ABITS, 7, DMI address width.
- IDLE_CYCLES, 3'd1, value reported in DTMCS.idle.

Ports:
- TCK  in  1  JTAG clock, from TGT_TCK_0. The only clock.
- TRSTB  in  1  asynchronous, active-high reset, from TGT_TRSTB_0 (active-high target reset).
- TMS  in  1  test mode select.
- TDI  in  1  test data in.
- TDO  out  1  test data out, to TGT_TDO_0.
- DMI_REQ_VALID  out  1  request valid.
- DMI_REQ_READY  in  1  DM accepts request.
- DMI_REQ_ADDR  out  ABITS  request address.
- DMI_REQ_DATA  out  32  write data.
- DMI_REQ_OP  out  2  1=read, 2=write.
- DMI_RESP_VALID  in  1  response valid.
- DMI_RESP_READY  out  1  DTM accepts response.
- DMI_RESP_DATA  in  32  read data.
- DMI_RESP_OP  in  2  0=ok, 2=failed; 1 and 3 are treated as failed.

Behaviour:
- Reset (TRSTB=1, async) forces:
  - TAP state Test-Logic-Reset; IR=5'h01 (IDCODE).
  - All shift registers, addr_q and data_q = 0; sticky=0, pending=0.
  - DMI_REQ_VALID=0, DMI_RESP_READY=0, TDO=0.
- TAP FSM, 16 IEEE 1149.1 states:
  - Advances on the TCK rising edge per TMS.
  - Five consecutive TMS=1 reach Test-Logic-Reset from any state.
  - While in Test-Logic-Reset, IR is held at IDCODE. DMI state is untouched.
- IR (5 bits):
  - Capture-IR loads 5'b00001.
  - Shift-IR shifts LSB first, TDI into the MSB.
  - Update-IR latches the shifted value.
  - Decode: 0x01 IDCODE, 0x10 DTMCS, 0x11 DMI; every other code selects BYPASS (1 bit, captures 0).
- DR shift: Capture-DR loads the selected register; Shift-DR shifts LSB first with TDI into the MSB.
- TDO:
  - Registered on the TCK falling edge.
  - Equals the LSB of the active shift register during Shift-IR/Shift-DR; 0 otherwise.
- DTMCS (32 bits):
  - Capture value: {14'b0, 2'b0, 1'b0, IDLE_CYCLES, sticky, ABITS[5:0], 4'd1}.
  - Update-DR bit16 (dmireset): sticky=0.
  - Update-DR bit17 (dmihardreset): sticky=0, pending=0, DMI_REQ_VALID=0, DMI_RESP_READY=0. In-flight request abandoned; a late response is ignored.
- DMI register (ABITS+34 bits) = {addr, data[31:0], op[1:0]}.
  - Capture-DR loads {addr_q, data_q, status}.
  - status = sticky if sticky≠0; else 3 if pending=1; else 0.
  - Capture while pending=1 also sets sticky=3.
- DMI Update-DR:
  - op∈{1,2}, sticky=0, pending=0: addr_q/data_q take the shifted values, pending=1, DMI_REQ_VALID=1 with addr/data/op registered on the same edge.
  - op∈{1,2}, pending=1: sticky=3; no request issued.
  - op=0 or op=3: no action.
- Request handshake:
  - DMI_REQ_VALID stays high, payload stable, until a cycle with DMI_REQ_READY=1.
  - On that edge VALID drops and DMI_RESP_READY rises.
- Response:
  - Accepted on an edge with DMI_RESP_VALID & DMI_RESP_READY: data_q=DMI_RESP_DATA, pending=0, DMI_RESP_READY=0.
  - If DMI_RESP_OP≠0, sticky=2, unless sticky is already nonzero (first error wins).
  - Same-cycle request and response handshake is not possible; the response is only accepted after the request handshake.
- Simultaneous Capture-DR (DMI) and response acceptance on the same edge: the response is applied first, so the capture sees the new data and status 0.
- Reset mid-transaction clears everything immediately. The DM must tolerate an abandoned request.
- Latency: write Update-DR → DMI_REQ_VALID on the same rising edge, registered; visible the next cycle.

Test Plan:
- Assert TRSTB, release, shift 32 DR bits with no IR scan → TDO yields 0x1000_0CFD LSB-first; DMI_REQ_VALID=0.
- Load IR=0x10, capture/shift DTMCS → 0x0000_1071 (idle=1, abits=7, version=1).
- DMI write addr 0x10, data 0xDEADBEEF, op=2; hold DMI_REQ_READY=0 for 3 cycles → VALID held, payload stable; READY=1 → VALID drops next cycle. Respond op=0 → next DMI capture status=0.
- DMI read addr 0x04 with DM responding data 0x12345678, op=0 → subsequent DMI capture returns data 0x12345678, status 0.
- Issue a second request while pending → capture status=3, DTMCS dmistat=3. Write DTMCS bit16 → dmistat=0. Next request is accepted once the response arrives.
- With a request pending, drive TMS=1 for 5 TCK → IR=IDCODE, pending unchanged. Then assert TRSTB → DMI_REQ_VALID=0 immediately (async), TDO=0.
